// File: rtl/riscv_cpu.sv
// riscv_cpu: single-cycle RV32I-subset processor.
// Fetch, decode, execute, memory access and write-back all finish in one clock.
// Every rising edge with reset low commits exactly one instruction.
// The block holds the PC, an instruction ROM, a 32x32 register file (instance
// reg_file) and a word-addressed data RAM (instance ram).
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   reset - asynchronous, active-high; clears PC, registers and RAM immediately
// Architectural state is observed hierarchically: pc_out, reg_file.reg_file[],
// ram.ram[].

// Register file: two combinational read ports, one write port, x0 hardwired to 0.
module riscv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] reg_file [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) reg_file[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            reg_file[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : reg_file[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : reg_file[raddr2];
endmodule

// Data RAM: word array, combinational read, write on the rising edge.
module riscv_dmem #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] idx,
    input  logic          we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] ram [0:DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (we) begin
            ram[idx] <= wdata;
        end
    end

    assign rdata = ram[idx];
endmodule

module riscv_cpu #(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string PROG_FILE  = ""
) (
    input  logic clk,
    input  logic reset
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    function automatic logic [31:0] default_word(input int idx);
        case (idx)
            0:       return 32'h00500093; // addi x1,x0,5
            1:       return 32'h00700213; // addi x4,x0,7
            2:       return 32'h00408533; // add  x10,x1,x4
            3:       return 32'h00A02C23; // sw   x10,24(x0)
            4:       return 32'h01802083; // lw   x1,24(x0)
            5:       return 32'h00A08463; // beq  x1,x10,+8
            6:       return 32'h06300213; // addi x4,x0,99
            7:       return 32'h40450233; // sub  x4,x10,x4
            8:       return 32'h0000006F; // jal  x0,0
            default: return 32'h00000000; // opcode 0 is not decoded: NOP
        endcase
    endfunction

    logic [31:0] rom [0:IMEM_DEPTH-1];

    // ROM image load; the array is only ever read by the datapath.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) rom[i] = default_word(i);
    end

    logic [31:0] pc_q, pc_d, pc_out, pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] alu_b, alu_res;
    logic        alu_alt;
    logic        br_taken;
    logic        rf_we, ram_we;
    logic [31:0] rf_wdata, mem_addr, ram_rdata;
    logic        unused_bits;

    assign pc_out   = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    // Fetch index wraps naturally by taking only the low PC word bits.
    assign instr  = rom[pc_q[IW+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    riscv_regfile reg_file (
        .clk    (clk),
        .rst    (reset),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata)
    );

    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    riscv_dmem #(.DEPTH(DMEM_DEPTH), .AW(DW)) ram (
        .clk   (clk),
        .rst   (reset),
        .idx   (mem_addr[DW+1:2]),
        .we    (ram_we),
        .wdata (rs2_val),
        .rdata (ram_rdata)
    );

    // funct7[5] selects sub/sra for register ops; for immediates only srai uses it.
    assign alu_b   = (opcode == OP_R) ? rs2_val : imm_i;
    assign alu_alt = instr[30] && ((opcode == OP_R) || (funct3 == 3'b101));

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
            3'b001: alu_res = rs1_val << alu_b[4:0];
            3'b010: alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'b0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: alu_res = alu_alt ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                      : (rs1_val >> alu_b[4:0]);
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d     = pc_plus4;
        rf_we    = 1'b0;
        rf_wdata = alu_res;
        ram_we   = 1'b0;
        case (opcode)
            OP_R, OP_IMM: rf_we = 1'b1;
            OP_LUI: begin
                rf_we    = 1'b1;
                rf_wdata = imm_u;
            end
            OP_LOAD: begin
                rf_we    = 1'b1;
                rf_wdata = ram_rdata;
            end
            OP_STORE: ram_we = 1'b1;
            OP_BRANCH: begin
                if (br_taken) pc_d = pc_q + imm_b;
            end
            OP_JAL: begin
                rf_we    = 1'b1;
                rf_wdata = pc_plus4;
                pc_d     = pc_q + imm_j;
            end
            OP_JALR: begin
                rf_we    = 1'b1;
                rf_wdata = pc_plus4;
                pc_d     = (rs1_val + imm_i) & ~32'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    assign unused_bits = ^{pc_q[31:IW+2], pc_q[1:0], mem_addr[31:DW+2], mem_addr[1:0]};
endmodule

// File: tb/tb_riscv_cpu.sv
module tb_riscv_cpu;
    logic clk;
    logic reset;

    int pass_cnt  = 0;
    int total_cnt = 0;

    riscv_cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LW = 3, K_SW = 4,
                   K_BR = 5, K_JAL = 6, K_JALR = 7, K_NOP = 8;

    typedef struct {
        int          kind;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } minst_t;

    typedef struct {
        int          edge_no;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r4;
        logic [31:0] r10;
        logic [31:0] ram6;
    } def_vec_t;

    minst_t      mprog [64];
    logic [31:0] m_reg [32];
    logic [31:0] m_ram [64];
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // Random instruction: returns the machine word and its meaning for the model.
    function automatic void gen(output logic [31:0] word, output minst_t m);
        int          k;
        logic [11:0] imm12;
        logic [4:0]  sh;
        logic [31:0] off;
        logic [24:0] junk;
        int          sel;
        k      = int'($urandom_range(0, 11));
        m.rd   = 5'($urandom_range(0, 15));
        m.rs1  = 5'($urandom_range(0, 15));
        m.rs2  = 5'($urandom_range(0, 15));
        m.f3   = 3'($urandom_range(0, 7));
        m.alt  = 1'b0;
        m.imm  = '0;
        imm12  = 12'($urandom_range(0, 4095));
        off    = 32'(int'($urandom_range(0, 16)) - 8) * 32'd4;
        word   = '0;
        case (k)
            0, 1: begin
                m.kind = K_R;
                if (m.f3 == 3'd0 || m.f3 == 3'd5) m.alt = 1'($urandom_range(0, 1));
                word = enc_r({1'b0, m.alt, 5'b0}, m.rs2, m.rs1, m.f3, m.rd);
            end
            2, 3, 4: begin
                m.kind = K_I;
                if (m.f3 == 3'd1 || m.f3 == 3'd5) begin
                    sh    = 5'($urandom_range(0, 31));
                    if (m.f3 == 3'd5) m.alt = 1'($urandom_range(0, 1));
                    m.imm = {27'b0, sh};
                    word  = enc_i({1'b0, m.alt, 5'b0, sh}, m.rs1, m.f3, m.rd, 7'h13);
                end else begin
                    m.imm = {{20{imm12[11]}}, imm12};
                    word  = enc_i(imm12, m.rs1, m.f3, m.rd, 7'h13);
                end
            end
            5: begin
                m.kind = K_LUI;
                m.imm  = {20'($urandom), 12'b0};
                word   = {m.imm[31:12], m.rd, 7'h37};
            end
            6: begin
                m.kind = K_LW;
                m.imm  = {{20{imm12[11]}}, imm12};
                word   = enc_i(imm12, m.rs1, 3'b010, m.rd, 7'h03);
            end
            7: begin
                m.kind = K_SW;
                m.imm  = {{20{imm12[11]}}, imm12};
                word   = enc_s(imm12, m.rs2, m.rs1);
            end
            8: begin
                m.kind = K_BR;
                sel    = int'($urandom_range(0, 3));
                m.f3   = (sel < 2) ? 3'(sel) : 3'(sel + 2);
                m.imm  = off;
                word   = enc_b(off[12:0], m.rs2, m.rs1, m.f3);
            end
            9: begin
                m.kind = K_JAL;
                m.imm  = off;
                word   = enc_j(off[20:0], m.rd);
            end
            10: begin
                m.kind = K_JALR;
                imm12  = 12'($urandom_range(0, 63));
                m.imm  = {20'b0, imm12};
                word   = enc_i(imm12, m.rs1, 3'b000, m.rd, 7'h67);
            end
            default: begin
                m.kind = K_NOP;
                junk   = 25'($urandom);
                word   = {junk, 7'h0b};
            end
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned amt;
        amt = int'(b & 32'd31);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << amt;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> amt) : a >> amt;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 64; i++) m_ram[i] = '0;
        m_pc = '0;
    endtask

    task automatic model_wr(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) m_reg[rd] = v;
    endtask

    // One instruction of architectural semantics.
    task automatic model_step();
        minst_t      m;
        logic [31:0] a, b, nxt;
        bit          taken;
        m   = mprog[(m_pc >> 2) % 64];
        a   = m_reg[m.rs1];
        b   = m_reg[m.rs2];
        nxt = m_pc + 32'd4;
        case (m.kind)
            K_R:   model_wr(m.rd, alu_ref(m.f3, m.alt, a, b));
            K_I:   model_wr(m.rd, alu_ref(m.f3, m.alt, a, m.imm));
            K_LUI: model_wr(m.rd, m.imm);
            K_LW:  model_wr(m.rd, m_ram[((a + m.imm) >> 2) % 64]);
            K_SW:  m_ram[((a + m.imm) >> 2) % 64] = b;
            K_BR: begin
                case (m.f3)
                    3'd0:    taken = (a == b);
                    3'd1:    taken = (a != b);
                    3'd4:    taken = ($signed(a) < $signed(b));
                    default: taken = ($signed(a) >= $signed(b));
                endcase
                if (taken) nxt = m_pc + m.imm;
            end
            K_JAL: begin
                model_wr(m.rd, m_pc + 32'd4);
                nxt = m_pc + m.imm;
            end
            K_JALR: begin
                nxt = (a + m.imm) & ~32'd1;
                model_wr(m.rd, m_pc + 32'd4);
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    def_vec_t vecs [10];

    initial begin
        logic [31:0] w;
        minst_t      mi;

        vecs[0] = '{1,  32'd4,  32'd5,  32'd0, 32'd0,  32'd0};
        vecs[1] = '{2,  32'd8,  32'd5,  32'd7, 32'd0,  32'd0};
        vecs[2] = '{3,  32'd12, 32'd5,  32'd7, 32'd12, 32'd0};
        vecs[3] = '{4,  32'd16, 32'd5,  32'd7, 32'd12, 32'd12};
        vecs[4] = '{5,  32'd20, 32'd12, 32'd7, 32'd12, 32'd12};
        vecs[5] = '{6,  32'd28, 32'd12, 32'd7, 32'd12, 32'd12};
        vecs[6] = '{7,  32'd32, 32'd12, 32'd5, 32'd12, 32'd12};
        vecs[7] = '{8,  32'd32, 32'd12, 32'd5, 32'd12, 32'd12};
        vecs[8] = '{9,  32'd32, 32'd12, 32'd5, 32'd12, 32'd12};
        vecs[9] = '{10, 32'd32, 32'd12, 32'd5, 32'd12, 32'd12};

        // Reset applied with the clock still low: state must clear without an edge.
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset_pc",   dut.pc_out,                 32'd0);
        check("reset_r1",   dut.reg_file.reg_file[1],   32'd0);
        check("reset_r4",   dut.reg_file.reg_file[4],   32'd0);
        check("reset_r10",  dut.reg_file.reg_file[10],  32'd0);
        check("reset_ram6", dut.ram.ram[6],             32'd0);
        #1 reset = 1'b0;

        // Default program, edge by edge.
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("def_e%0d_pc",   vecs[i].edge_no), dut.pc_out,                vecs[i].pc);
            check($sformatf("def_e%0d_r1",   vecs[i].edge_no), dut.reg_file.reg_file[1],  vecs[i].r1);
            check($sformatf("def_e%0d_r4",   vecs[i].edge_no), dut.reg_file.reg_file[4],  vecs[i].r4);
            check($sformatf("def_e%0d_r10",  vecs[i].edge_no), dut.reg_file.reg_file[10], vecs[i].r10);
            check($sformatf("def_e%0d_ram6", vecs[i].edge_no), dut.ram.ram[6],            vecs[i].ram6);
        end

        // Reset in the middle of a run, between edges.
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid_pre_r1", dut.reg_file.reg_file[1], 32'd12);
        reset = 1'b1;
        #1;
        check("mid_pc",   dut.pc_out,                32'd0);
        check("mid_r1",   dut.reg_file.reg_file[1],  32'd0);
        check("mid_r4",   dut.reg_file.reg_file[4],  32'd0);
        check("mid_r10",  dut.reg_file.reg_file[10], 32'd0);
        check("mid_ram6", dut.ram.ram[6],            32'd0);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("rerun_pc",   dut.pc_out,                32'd32);
        check("rerun_r1",   dut.reg_file.reg_file[1],  32'd12);
        check("rerun_r4",   dut.reg_file.reg_file[4],  32'd5);
        check("rerun_r10",  dut.reg_file.reg_file[10], 32'd12);
        check("rerun_ram6", dut.ram.ram[6],            32'd12);

        // Writes to x0 are dropped and x0 reads as zero.
        reset = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) dut.rom[i] = 32'h0;
        dut.rom[0] = 32'h00900013; // addi x0,x0,9
        dut.rom[1] = 32'h00000133; // add  x2,x0,x0
        #1 reset = 1'b0;
        step();
        step();
        check("x0_stored", dut.reg_file.reg_file[0], 32'd0);
        check("x0_r2",     dut.reg_file.reg_file[2], 32'd0);
        check("x0_pc",     dut.pc_out,               32'd8);

        // PC runs past the ROM and the fetch index wraps back to word 0.
        reset = 1'b1;
        #1;
        dut.rom[0] = 32'h00118193; // addi x3,x3,1
        dut.rom[1] = 32'h0;
        #1 reset = 1'b0;
        for (int i = 0; i < 128; i++) step();
        check("wrap_r3", dut.reg_file.reg_file[3], 32'd2);
        check("wrap_pc", dut.pc_out,               32'd512);

        // Random programs against the architectural model.
        for (int p = 0; p < 15; p++) begin
            reset = 1'b1;
            #1;
            for (int i = 0; i < 64; i++) begin
                gen(w, mi);
                mprog[i]   = mi;
                dut.rom[i] = w;
            end
            model_reset();
            #1 reset = 1'b0;
            for (int c = 0; c < 64; c++) begin
                model_step();
                step();
                check($sformatf("rnd%0d_c%0d_pc", p, c), dut.pc_out, m_pc);
            end
            for (int r = 1; r < 32; r++)
                check($sformatf("rnd%0d_x%0d", p, r), dut.reg_file.reg_file[r], m_reg[r]);
            for (int a = 0; a < 64; a++)
                check($sformatf("rnd%0d_ram%0d", p, a), dut.ram.ram[a], m_ram[a]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
